// File: rtl/stream_seq_checker.sv
// Stream sequence checker: expects each burst to count 0,1,2.. on addr/data.
// Optional STREAM_SEQ_CHECKER_CAPTURE_EN adds capture of the first bad beat.
`timescale 1ns/1ps
module stream_seq_checker #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   input  logic                  valid_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  clr,
   output logic [CNT_WIDTH-1:0]  beat_cnt,
   output logic [CNT_WIDTH-1:0]  burst_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  err_flag,
   output logic                  busy
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
   ,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic [DATA_WIDTH-1:0] first_err_data
`endif
);

   typedef enum logic {IDLE, RUN} state_e;

   localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] A_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] D_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
   logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
   logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
   logic                  err_flag_q, err_flag_d;
   logic [ADDR_WIDTH-1:0] cur_exp_addr;
   logic [DATA_WIDTH-1:0] cur_exp_data;
   logic                  mismatch;

   // State register
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (valid_in)  state_d = RUN;
            RUN:  if (!valid_in) state_d = IDLE;
         endcase
      end
   end

   // A burst's first beat always expects zero, regardless of stale history
   always_comb begin
      cur_exp_addr = (state_q == RUN) ? exp_addr_q : '0;
      cur_exp_data = (state_q == RUN) ? exp_data_q : '0;
      mismatch     = valid_in &&
                     ((addr_in != cur_exp_addr) || (data_in != cur_exp_data));
   end

   always_comb begin
      exp_addr_d  = exp_addr_q;
      exp_data_d  = exp_data_q;
      beat_cnt_d  = beat_cnt_q;
      burst_cnt_d = burst_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_flag_d  = err_flag_q;
      if (clr) begin
         exp_addr_d  = '0;
         exp_data_d  = '0;
         beat_cnt_d  = '0;
         burst_cnt_d = '0;
         err_cnt_d   = '0;
         err_flag_d  = 1'b0;
      end else if (valid_in) begin
         exp_addr_d = addr_in + A_ONE;
         exp_data_d = data_in + D_ONE;
         if (beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + CNT_ONE;
         if (mismatch) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
         end
      end else begin
         exp_addr_d = '0;
         exp_data_d = '0;
         if (state_q == RUN && burst_cnt_q != CNT_MAX) begin
            burst_cnt_d = burst_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         exp_addr_q  <= '0;
         exp_data_q  <= '0;
         beat_cnt_q  <= '0;
         burst_cnt_q <= '0;
         err_cnt_q   <= '0;
         err_flag_q  <= 1'b0;
      end else begin
         exp_addr_q  <= exp_addr_d;
         exp_data_q  <= exp_data_d;
         beat_cnt_q  <= beat_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_flag_q  <= err_flag_d;
      end
   end

`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
   logic [ADDR_WIDTH-1:0] fe_addr_q, fe_addr_d;
   logic [DATA_WIDTH-1:0] fe_data_q, fe_data_d;

   // Only the first bad beat since reset/clr is latched
   always_comb begin
      fe_addr_d = fe_addr_q;
      fe_data_d = fe_data_q;
      if (clr) begin
         fe_addr_d = '0;
         fe_data_d = '0;
      end else if (mismatch && !err_flag_q) begin
         fe_addr_d = addr_in;
         fe_data_d = data_in;
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         fe_addr_q <= '0;
         fe_data_q <= '0;
      end else begin
         fe_addr_q <= fe_addr_d;
         fe_data_q <= fe_data_d;
      end
   end

   assign first_err_addr = fe_addr_q;
   assign first_err_data = fe_data_q;
`endif

   // Output logic
   always_comb begin
      busy      = (state_q == RUN);
      beat_cnt  = beat_cnt_q;
      burst_cnt = burst_cnt_q;
      err_cnt   = err_cnt_q;
      err_flag  = err_flag_q;
   end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Randomised + directed bench for stream_seq_checker against a burst model.
// Uses a 32/32/16 instance and a 4/4/4 instance for wrap/saturation cases.
`timescale 1ns/1ps
module tb_stream_seq_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        va, ca, vb, cb;
   logic [31:0] aa, da;
   logic [3:0]  ab, db;
   logic [15:0] beat_a, burst_a, err_a;
   logic [3:0]  beat_b, burst_b, err_b;
   logic        flag_a, busy_a, flag_b, busy_b;
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
   logic [31:0] fea_a, fed_a;
   logic [3:0]  fea_b, fed_b;
`endif

   int errors = 0;
   int checks = 0;

   stream_seq_checker u_a (
      .clk(clk), .sys_rst_n(rst_n), .valid_in(va), .addr_in(aa),
      .data_in(da), .clr(ca), .beat_cnt(beat_a), .burst_cnt(burst_a),
      .err_cnt(err_a), .err_flag(flag_a), .busy(busy_a)
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
      , .first_err_addr(fea_a), .first_err_data(fed_a)
`endif
   );

   stream_seq_checker #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .CNT_WIDTH(4)) u_b (
      .clk(clk), .sys_rst_n(rst_n), .valid_in(vb), .addr_in(ab),
      .data_in(db), .clr(cb), .beat_cnt(beat_b), .burst_cnt(burst_b),
      .err_cnt(err_b), .err_flag(flag_b), .busy(busy_b)
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
      , .first_err_addr(fea_b), .first_err_data(fed_b)
`endif
   );

   // Reference model: per-instance burst bookkeeping
   int     m_beat[2], m_burst[2], m_err[2];
   bit     m_flag[2], m_run[2];
   longint m_prev_a[2], m_prev_d[2], m_fea[2], m_fed[2];

   task automatic model_rst();
      for (int k = 0; k < 2; k++) begin
         m_beat[k] = 0; m_burst[k] = 0; m_err[k] = 0;
         m_flag[k] = 0; m_run[k] = 0;
         m_prev_a[k] = 0; m_prev_d[k] = 0; m_fea[k] = 0; m_fed[k] = 0;
      end
   endtask

   task automatic model(int k, bit v, longint a, longint d, bit c);
      longint mask = (k == 0) ? 64'hFFFF_FFFF : 64'hF;
      int     cmax = (k == 0) ? 65535 : 15;
      longint ea, ed;
      if (c) begin
         m_beat[k] = 0; m_burst[k] = 0; m_err[k] = 0;
         m_flag[k] = 0; m_run[k] = 0; m_fea[k] = 0; m_fed[k] = 0;
      end else if (v) begin
         ea = m_run[k] ? ((m_prev_a[k] + 1) & mask) : 0;
         ed = m_run[k] ? ((m_prev_d[k] + 1) & mask) : 0;
         if (a != ea || d != ed) begin
            if (!m_flag[k]) begin m_fea[k] = a; m_fed[k] = d; end
            m_flag[k] = 1;
            if (m_err[k] < cmax) m_err[k]++;
         end
         if (m_beat[k] < cmax) m_beat[k]++;
         m_prev_a[k] = a; m_prev_d[k] = d; m_run[k] = 1;
      end else if (m_run[k]) begin
         if (m_burst[k] < cmax) m_burst[k]++;
         m_run[k] = 0;
      end
   endtask

   // One clock: drive instance k, idle the other, advance both models
   task automatic step(int k, bit v, logic [31:0] a, logic [31:0] d, bit c);
      if (k == 0) begin
         va = v; aa = a; da = d; ca = c; vb = 0; cb = 0;
         model(0, v, longint'(a), longint'(d), c);
         model(1, 0, 0, 0, 0);
      end else begin
         vb = v; ab = a[3:0]; db = d[3:0]; cb = c; va = 0; ca = 0;
         model(1, v, longint'(a[3:0]), longint'(d[3:0]), c);
         model(0, 0, 0, 0, 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; va = 0; ca = 0; vb = 0; cb = 0;
      aa = 0; da = 0; ab = 0; db = 0;
      model_rst();
      #12;
      checks++;
      if ({beat_a, burst_a, err_a} !== 48'd0) begin
         errors++;
         $display("FAIL reset_cnt_a: got %0h expected 0",
                  {beat_a, burst_a, err_a});
      end
      checks++;
      if ({flag_a, busy_a, flag_b, busy_b} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {flag_a, busy_a, flag_b, busy_b});
      end
      #11 rst_n = 1;
   endtask

   task automatic test_burst8();
      for (int i = 0; i < 8; i++) begin
         step(0, 1, i, i, 0);
         if (i == 0) begin
            checks++;
            if (busy_a !== 1'b1) begin
               errors++;
               $display("FAIL busy_run: got %b expected 1", busy_a);
            end
         end
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if (beat_a !== 16'd8 || burst_a !== 16'd1 || err_a !== 16'd0 ||
          flag_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL burst8: got beat=%0d burst=%0d err=%0d flag=%b busy=%b expected 8 1 0 0 0",
                  beat_a, burst_a, err_a, flag_a, busy_a);
      end
   endtask

   task automatic test_gap_error();
      int seq[5] = '{0, 1, 2, 5, 6};
      step(0, 0, 0, 0, 1);
      foreach (seq[i]) step(0, 1, seq[i], seq[i], 0);
      step(0, 0, 0, 0, 0);
      checks++;
      if (err_a !== 16'd1 || flag_a !== 1'b1 || beat_a !== 16'd5) begin
         errors++;
         $display("FAIL gap_error: got err=%0d flag=%b beat=%0d expected 1 1 5",
                  err_a, flag_a, beat_a);
      end
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
      checks++;
      if (fea_a !== 32'd5 || fed_a !== 32'd5) begin
         errors++;
         $display("FAIL first_err: got %0d/%0d expected 5/5", fea_a, fed_a);
      end
`endif
   endtask

   task automatic test_wrap();
      step(1, 0, 0, 0, 1);
      for (int i = 0; i < 18; i++) step(1, 1, i % 16, i % 16, 0);
      step(1, 0, 0, 0, 0);
      checks++;
      if (err_b !== 4'd0 || flag_b !== 1'b0) begin
         errors++;
         $display("FAIL wrap_err: got err=%0d flag=%b expected 0 0",
                  err_b, flag_b);
      end
      checks++;
      if (beat_b !== 4'd15 || burst_b !== 4'd1) begin
         errors++;
         $display("FAIL wrap_cnt: got beat=%0d burst=%0d expected 15 1",
                  beat_b, burst_b);
      end
   endtask

   task automatic test_err_saturate();
      step(1, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(1, 1, 3, 3, 0);
      step(1, 0, 0, 0, 0);
      checks++;
      if (err_b !== 4'd15 || flag_b !== 1'b1) begin
         errors++;
         $display("FAIL err_sat: got err=%0d flag=%b expected 15 1",
                  err_b, flag_b);
      end
   endtask

   task automatic test_clr_priority();
      for (int i = 0; i < 3; i++) step(0, 1, i, i, 0);
      step(0, 1, 3, 3, 1);
      checks++;
      if ({beat_a, burst_a, err_a} !== 48'd0 || busy_a !== 1'b0 ||
          flag_a !== 1'b0) begin
         errors++;
         $display("FAIL clr_prio: got beat=%0d burst=%0d err=%0d busy=%b flag=%b expected 0s",
                  beat_a, burst_a, err_a, busy_a, flag_a);
      end
      step(0, 1, 0, 0, 0);
      checks++;
      if (err_a !== 16'd0 || beat_a !== 16'd1 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL clr_resume: got err=%0d beat=%0d busy=%b expected 0 1 1",
                  err_a, beat_a, busy_a);
      end
      step(0, 0, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, i, i, 0);
      va = 0;
      #3 rst_n = 0;
      model_rst();
      #1;
      checks++;
      if ({beat_a, burst_a, err_a} !== 48'd0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: got beat=%0d burst=%0d err=%0d busy=%b expected 0s",
                  beat_a, burst_a, err_a, busy_a);
      end
      #2 rst_n = 1;
      for (int i = 0; i < 5; i++) step(0, 1, i, i, 0);
      step(0, 0, 0, 0, 0);
      checks++;
      if (burst_a !== 16'd1 || beat_a !== 16'd5 || err_a !== 16'd0) begin
         errors++;
         $display("FAIL post_rst: got burst=%0d beat=%0d err=%0d expected 1 5 0",
                  burst_a, beat_a, err_a);
      end
   endtask

   task automatic test_random();
      bit          v, c;
      logic [31:0] a, d;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 9) < 8);
         c = ($urandom_range(0, 59) == 0);
         if (!m_run[0]) begin
            a = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFE : 32'd0;
            d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
         end else begin
            a = 32'(m_prev_a[0] + 1);
            d = 32'(m_prev_d[0] + 1);
            if ($urandom_range(0, 11) == 0) a = $urandom;
            if ($urandom_range(0, 11) == 0) d = $urandom;
         end
         step(0, v, a, d, c);
         checks++;
         if (beat_a !== 16'(m_beat[0]) || burst_a !== 16'(m_burst[0]) ||
             err_a !== 16'(m_err[0]) || flag_a !== m_flag[0] ||
             busy_a !== m_run[0]) begin
            errors++;
            $display("FAIL rand_%0d: got %0d/%0d/%0d/%b/%b expected %0d/%0d/%0d/%b/%b",
                     i, beat_a, burst_a, err_a, flag_a, busy_a,
                     m_beat[0], m_burst[0], m_err[0], m_flag[0], m_run[0]);
         end
`ifdef STREAM_SEQ_CHECKER_CAPTURE_EN
         checks++;
         if (fea_a !== 32'(m_fea[0]) || fed_a !== 32'(m_fed[0])) begin
            errors++;
            $display("FAIL rand_cap_%0d: got %0h/%0h expected %0h/%0h",
                     i, fea_a, fed_a, m_fea[0], m_fed[0]);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_burst8();
      test_gap_error();
      test_wrap();
      test_err_saturate();
      test_clr_priority();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
